// File: rtl/sr_pulse_pkg.sv
// Shared types and helpers for the SR pulse generator and its debouncers.
// Optional lockout is enabled by defining SRPG_LOCKOUT_EN.
package sr_pulse_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } db_state_t;

  // Bits needed to hold a count of 0..cycles inclusive.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM with saturating
// counter, and a registered one-cycle pulse on each accepted press.
module sr_debounce
  import sr_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // A change is accepted once sync2 has held the new level for
  // DEBOUNCE_CYCLES consecutive samples; any bounce restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      state  <= S_LOW;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      case (state)
        S_LOW: begin
          if (sync2) begin
            if (CNT_LAST == '0) begin
              state  <= S_HIGH;
              stable <= 1'b1;
              rise   <= 1'b1;
              cnt    <= '0;
            end else begin
              state <= S_RISE;
              cnt   <= CW'(1);
            end
          end
        end
        S_RISE: begin
          if (!sync2) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state  <= S_HIGH;
            stable <= 1'b1;
            rise   <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!sync2) begin
            if (CNT_LAST == '0) begin
              state  <= S_LOW;
              stable <= 1'b0;
              cnt    <= '0;
            end else begin
              state <= S_FALL;
              cnt   <= CW'(1);
            end
          end
        end
        S_FALL: begin
          if (sync2) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state  <= S_LOW;
            stable <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced set/reset pulse driver for a downstream SR flop; s and r are
// mutually exclusive. Define SRPG_LOCKOUT_EN to add a post-pulse lockout.
module sr_pulse_gen
  import sr_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  logic set_stable, set_rise;
  logic rst_stable, rst_rise;
  logic fire_s, fire_r;
  logic locked;
  logic accept_s, accept_r;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (set_btn),
    .stable (set_stable),
    .rise   (set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (rst_btn),
    .stable (rst_stable),
    .rise   (rst_rise)
  );

  assign fire_s   = set_rise & set_stable;
  assign fire_r   = rst_rise & rst_stable;
  assign accept_s = fire_s & ~fire_r & ~locked;
  assign accept_r = fire_r & ~fire_s & ~locked;

`ifdef SRPG_LOCKOUT_EN
  localparam int LW = cnt_width(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  logic [LW-1:0] lock_cnt;

  // Reloaded by every issued pulse; rises arriving while nonzero are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (accept_s || accept_r) begin
      lock_cnt <= LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  assign locked = (lock_cnt != '0);
`else
  assign locked = 1'b0;
`endif

  assign busy = locked;

  // Simultaneous accepted presses cancel each other and only flag conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= accept_s;
      r        <= accept_r;
      conflict <= fire_s & fire_r & ~locked;
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: stimulus queues expected pulses with
// their edge number, a negedge monitor pops and compares each observed pulse.
module tb_sr_pulse_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic set_btn;
  logic rst_btn;
  logic s, r, conflict, busy;

  localparam logic [2:0] K_S = 3'b100;
  localparam logic [2:0] K_R = 3'b010;
  localparam logic [2:0] K_C = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   checks = 0;
  int   passed = 0;

  sr_pulse_gen #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_btn  (set_btn),
    .rst_btn  (rst_btn),
    .s        (s),
    .r        (r),
    .conflict (conflict),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_n);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic set_v, input logic rst_v);
    set_btn = set_v;
    rst_btn = rst_v;
  endtask

  // Inputs applied now are sampled at edge_n+1; pulse visible after that edge + offset.
  task automatic expectPulse(input logic [2:0] kind, input int offset);
    exp_t e;
    e.kind = kind;
    e.at   = edge_n + 1 + offset;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (s || r || conflict) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_pulse: got s=%b r=%b conflict=%b, expected none (edge %0d)",
                 s, r, conflict, edge_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pulse_kind", {29'd0, s, r, conflict}, {29'd0, e.kind});
        checkOutput("pulse_edge", edge_n, e.at);
        checkOutput("s_r_exclusive", {31'd0, s & r}, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #2;
    checkOutput("reset_s", {31'd0, s}, 32'd0);
    checkOutput("reset_r", {31'd0, r}, 32'd0);
    checkOutput("reset_conflict", {31'd0, conflict}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Clean held press: one pulse after E+6, nothing more while held
    applyStimulus(1'b1, 1'b0);
    expectPulse(K_S, 6);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);

    // Bounce rejected, pulse 6 edges after the final rise
    applyStimulus(1'b1, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b0); tick(1);
    applyStimulus(1'b1, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b0); tick(1);
    applyStimulus(1'b1, 1'b0);
    expectPulse(K_S, 6);
    tick(15);
    applyStimulus(1'b0, 1'b0);
    tick(12);

    // Simultaneous presses give conflict only; a later set press works
    applyStimulus(1'b1, 1'b1);
    expectPulse(K_C, 6);
    tick(15);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    applyStimulus(1'b1, 1'b0);
    expectPulse(K_S, 6);
    tick(12);
    applyStimulus(1'b0, 1'b0);
    tick(12);

    // Reset button press, release, press: two r pulses 20 edges apart
    applyStimulus(1'b0, 1'b1);
    expectPulse(K_R, 6);
    tick(10);
    applyStimulus(1'b0, 1'b0);
    tick(10);
    applyStimulus(1'b0, 1'b1);
    expectPulse(K_R, 6);
    tick(10);
    applyStimulus(1'b0, 1'b0);
    tick(12);

    // Reset mid-debounce (S_RISE, cnt=2) discards the press
    applyStimulus(1'b1, 1'b0);
    tick(4);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_s", {31'd0, s}, 32'd0);
    checkOutput("midreset_r", {31'd0, r}, 32'd0);
    checkOutput("midreset_conflict", {31'd0, conflict}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    expectPulse(K_S, 6);
    tick(14);
    applyStimulus(1'b0, 1'b0);
    tick(12);

`ifdef SRPG_LOCKOUT_EN
    begin
      int x;
      checkOutput("lock_idle_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 1'b0);
      expectPulse(K_S, 6);
      x = edge_n + 7;
      tick(4);
      applyStimulus(1'b1, 1'b1);
      tick(3);
      checkOutput("lock_busy_start", {31'd0, busy}, 32'd1);
      checkOutput("lock_edge_align", edge_n, x);
      tick(7);
      checkOutput("lock_busy_last", {31'd0, busy}, 32'd1);
      tick(1);
      checkOutput("lock_busy_end", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 1'b0);
      tick(12);
      applyStimulus(1'b0, 1'b1);
      expectPulse(K_R, 6);
      tick(12);
      applyStimulus(1'b0, 1'b0);
      tick(12);
    end
`else
    applyStimulus(1'b1, 1'b0);
    expectPulse(K_S, 6);
    tick(7);
    checkOutput("nolock_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick(12);
`endif

    checkOutput("queue_empty", sb.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
